ethernet_ip_stream_scheduler: RTL
=================================

# ethernet_ip_stream_scheduler

Round-robin scheduler that shares one IPv4 packet generator datapath (header request + payload + Ethernet framing) among up to NUM_STREAMS independently configured traffic streams. Each stream has its own packet budget and inter-packet gap. The scheduler issues one packet request at a time, tagged with stream ID and per-stream sequence number, and waits for the datapath's completion pulse before arbitrating again. It sits between the AVMM register block (stream config) and the packet source (header/payload generation).

## Interface
Parameters:
- NUM_STREAMS, 4: number of streams, 2..16.
- SID_W, $clog2(NUM_STREAMS): stream ID width (derived; do not override).

Ports:
- clk_ifc  in  Clock_int.Input  single clock; all logic in this domain.
- sreset_ifc  in  Reset_int.ResetIn  synchronous, active-high reset.
- stream_en  in  [NUM_STREAMS]  level; stream eligible only while high.
- stream_start  in  [NUM_STREAMS]  1-cycle pulse per stream; loads budget, clears seq/sent/gap.
- stream_num_packets  in  [NUM_STREAMS][32]  budget sampled on start; 0 = continuous.
- stream_interval  in  [NUM_STREAMS][16]  gap in cycles after that stream's completion.
- req_valid  out  1  packet request to datapath.
- req_ready  in  1  datapath accepts request.
- req_stream  out  SID_W  stream ID of request.
- req_seq  out  32  per-stream sequence number of request (0-based).
- pkt_done  in  1  1-cycle pulse: in-flight packet fully sent.
- stream_active  out  [NUM_STREAMS]  en & (continuous | remaining != 0).
- stream_sent  out  [NUM_STREAMS][32]  completed packets, saturating at 2^32-1.
- busy  out  1  high in ISSUE or WAIT_DONE.

## Operation
- Per-stream state: remaining[32], cont flag, seq[32], gap[16], sent[32].
- stream_start[i]: remaining<=num_packets[i], cont<=(num_packets[i]==0), seq<=0, sent<=0, gap<=0. Does not abort an in-flight packet.
- Eligible[i] = stream_en[i] & (cont[i] | remaining[i]!=0) & gap[i]==0.
- FSM ARB: if any eligible, grant first eligible searching from rr_ptr+1 (wrapping); latch req_stream<=i, req_seq<=seq[i]; rr_ptr<=i; go ISSUE. Else stay.
- ISSUE: req_valid=1; on req_ready: seq[i]++ (wraps), remaining[i]-- unless cont; go WAIT_DONE.
- WAIT_DONE: on pkt_done: sent[i]++ (saturate), gap[i]<=stream_interval[i]; go ARB.
- gap[i] decrements by 1 each cycle while nonzero, independent of FSM.
- pkt_done outside WAIT_DONE ignored. stream_en falling during ISSUE/WAIT_DONE: request still completes.
- stream_start[i] coincident with handshake or pkt_done for stream i: start wins (counters take start values; no decrement/increment/gap load).

## Timing
- Reset: FSM=ARB, req_valid=0, req_stream=0, req_seq=0, busy=0, rr_ptr=NUM_STREAMS-1 (stream 0 first), all per-stream state 0, stream_active=0, stream_sent=0.
- req_valid asserts the cycle after an ARB grant; req_stream/req_seq stable while req_valid high; req_valid held until req_ready (no withdrawal).
- pkt_done sampled at edge t: gap=interval during t+1, zero at t+1+interval; next req_valid for that stream earliest at t+2+interval; with interval=0 at t+2.
- Minimum request spacing: 3 cycles (ARB, ISSUE, WAIT_DONE) with immediate ready/done.
- Outputs stream_active, stream_sent registered or derived combinationally from registered state only.

## Test plan
- Single stream 0: num_packets=3, interval=0, ready tied 1, done 1 cycle after handshake -> 3 requests, req_seq 0,1,2, stream_sent[0]=3, stream_active[0]=0 after third handshake, no 4th request.
- Streams 0-3 all continuous, interval=0 -> grant order 0,1,2,3,0,1... for 12 requests; each req_seq increments once per round.
- Stream 1 interval=10, sole enabled stream, done at cycle t -> next req_valid exactly at t+12.
- Backpressure: req_ready low 5 cycles -> req_valid, req_stream, req_seq held constant; one handshake; remaining decrements once.
- stream_start[2] pulsed same cycle as pkt_done for stream 2 (num_packets=5) -> sent[2]=0, seq=0, remaining=5, gap=0; stream 2 requests again at t+2 with req_seq=0.
- Reset asserted in WAIT_DONE -> next cycle all outputs at reset values; later pkt_done ignored; no request until stream_start+en.

Source files
------------

// File: rtl/ethernet_ip_stream_scheduler_if.sv
// Request/completion handshake between the stream scheduler (master) and the
// shared packet datapath (slave).
interface ethernet_ip_stream_scheduler_if #(
  parameter int SID_W = 2
);
  logic             req_valid;
  logic             req_ready;
  logic [SID_W-1:0] req_stream;
  logic [31:0]      req_seq;
  logic             pkt_done;

  modport master (output req_valid, req_stream, req_seq, input req_ready, pkt_done);
  modport slave  (input req_valid, req_stream, req_seq, output req_ready, pkt_done);
endinterface

// File: rtl/ethernet_ip_stream_scheduler.sv
// Round-robin scheduler sharing one packet datapath among NUM_STREAMS streams,
// each with its own packet budget, sequence counter and inter-packet gap.
module ethernet_ip_stream_scheduler #(
  parameter int NUM_STREAMS = 4,
  parameter int SID_W       = $clog2(NUM_STREAMS)
) (
  input  logic                           clk_ifc,
  input  logic                           sreset_ifc,
  input  logic [NUM_STREAMS-1:0]         stream_en,
  input  logic [NUM_STREAMS-1:0]         stream_start,
  input  logic [NUM_STREAMS-1:0][31:0]   stream_num_packets,
  input  logic [NUM_STREAMS-1:0][15:0]   stream_interval,
  ethernet_ip_stream_scheduler_if.master req_if,
  output logic [NUM_STREAMS-1:0]         stream_active,
  output logic [NUM_STREAMS-1:0][31:0]   stream_sent,
  output logic                           busy
);

  typedef enum logic [1:0] {ST_ARB, ST_ISSUE, ST_WAIT_DONE} state_t;

  state_t                       state;
  logic [NUM_STREAMS-1:0][31:0] remaining;
  logic [NUM_STREAMS-1:0][31:0] seq;
  logic [NUM_STREAMS-1:0][31:0] sent;
  logic [NUM_STREAMS-1:0][15:0] gap;
  logic [NUM_STREAMS-1:0]       cont;
  logic [NUM_STREAMS-1:0]       has_budget;
  logic [NUM_STREAMS-1:0]       eligible;
  logic [SID_W-1:0]             rr_ptr;
  logic [SID_W-1:0]             grant_idx;
  logic [SID_W:0]               cand;
  logic                         grant_found;
  logic                         req_valid_q;
  logic [SID_W-1:0]             req_stream_q;
  logic [31:0]                  req_seq_q;

  always_comb begin
    for (int i = 0; i < NUM_STREAMS; i++) begin
      has_budget[i] = cont[i] | (remaining[i] != '0);
      eligible[i]   = stream_en[i] & has_budget[i] & (gap[i] == '0);
    end
  end

  // Search starts one past the last grant; cand is one bit wider so the wrap
  // can be done with a single conditional subtract for any NUM_STREAMS.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_STREAMS; k++) begin
      cand = {1'b0, rr_ptr} + (SID_W+1)'(k);
      if (cand >= (SID_W+1)'(NUM_STREAMS)) cand = cand - (SID_W+1)'(NUM_STREAMS);
      if (!grant_found && eligible[cand[SID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[SID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_ifc) begin
    if (sreset_ifc) begin
      // NOTE: per-stream state is held in flops (not RAM), so it is reset along with the FSM.
      state        <= ST_ARB;
      rr_ptr       <= SID_W'(NUM_STREAMS - 1);
      req_valid_q  <= 1'b0;
      req_stream_q <= '0;
      req_seq_q    <= '0;
      busy         <= 1'b0;
      remaining    <= '0;
      cont         <= '0;
      seq          <= '0;
      gap          <= '0;
      sent         <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
      for (int i = 0; i < NUM_STREAMS; i++) begin
        if (gap[i] != '0) gap[i] <= gap[i] - 16'd1;
      end

      case (state)
        ST_ARB: begin
          if (grant_found) begin
            req_stream_q <= grant_idx;
            req_seq_q    <= seq[grant_idx];
            rr_ptr       <= grant_idx;
            req_valid_q  <= 1'b1;
            busy         <= 1'b1;
            state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (req_if.req_ready) begin
            seq[req_stream_q] <= seq[req_stream_q] + 32'd1;
            if (!cont[req_stream_q]) remaining[req_stream_q] <= remaining[req_stream_q] - 32'd1;
            req_valid_q <= 1'b0;
            state       <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (req_if.pkt_done) begin
            if (sent[req_stream_q] != '1) sent[req_stream_q] <= sent[req_stream_q] + 32'd1;
            gap[req_stream_q] <= stream_interval[req_stream_q];
            busy              <= 1'b0;
            state             <= ST_ARB;
          end
        end
        default: state <= ST_ARB;
      endcase

      // NOTE: the last non-blocking write to a flop in a block wins, which gives start priority over handshake/done updates.
      for (int i = 0; i < NUM_STREAMS; i++) begin
        if (stream_start[i]) begin
          remaining[i] <= stream_num_packets[i];
          cont[i]      <= (stream_num_packets[i] == '0);
          seq[i]       <= '0;
          sent[i]      <= '0;
          gap[i]       <= '0;
        end
      end
    end
  end

  assign req_if.req_valid  = req_valid_q;
  assign req_if.req_stream = req_stream_q;
  assign req_if.req_seq    = req_seq_q;
  assign stream_active     = stream_en & has_budget;
  assign stream_sent       = sent;

endmodule
